// File: rtl/riscv_pkg.sv
// Shared RV32 constants and types for the EX-stage multiplier.
package riscv_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 5;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/mul_sign_fix.sv
// Operand magnitude/sign decode at start, and sign-correct + slice of the 64-bit product.
// Latency: combinational. Backpressure: none.
module mul_sign_fix
    import riscv_pkg::*;
(
    input  logic [2:0]        funct3_i,
    input  logic [XLEN-1:0]   src_a_i,
    input  logic [XLEN-1:0]   src_b_i,
    output logic [XLEN-1:0]   mag_a_o,
    output logic [XLEN-1:0]   mag_b_o,
    output logic              neg_o,
    input  logic [2:0]        res_funct3_i,
    input  logic              res_neg_i,
    input  logic [2*XLEN-1:0] prod_i,
    output logic [XLEN-1:0]   result_o
);

    logic              a_sgn;
    logic              b_sgn;
    logic [2*XLEN-1:0] prod_fix;

    always_comb begin
        a_sgn   = ((funct3_i == F3_MULH) || (funct3_i == F3_MULHSU)) && src_a_i[XLEN-1];
        b_sgn   = (funct3_i == F3_MULH) && src_b_i[XLEN-1];
        // 0x80000000 negates to itself, which is the correct unsigned magnitude
        mag_a_o = a_sgn ? (~src_a_i + 1'b1) : src_a_i;
        mag_b_o = b_sgn ? (~src_b_i + 1'b1) : src_b_i;
        neg_o   = a_sgn ^ b_sgn;

        prod_fix = res_neg_i ? (~prod_i + 1'b1) : prod_i;
        if ((res_funct3_i == F3_MULH) || (res_funct3_i == F3_MULHSU) || (res_funct3_i == F3_MULHU))
            result_o = prod_fix[2*XLEN-1:XLEN];
        else
            result_o = prod_fix[XLEN-1:0];
    end

endmodule

// File: rtl/mul_unit_ex.sv
// Iterative radix-2 shift-add RV32M multiplier in EX; result registered on BUSY->DONE.
// Latency: 33 stall cycles, mul_doneE one cycle later; stall_mulE holds the pipeline meanwhile.
module mul_unit_ex
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            startE,
    input  logic            flushE,
    input  logic [2:0]      funct3E,
    input  logic [XLEN-1:0] SrcAE,
    input  logic [XLEN-1:0] SrcBE,
    output logic [XLEN-1:0] multiplier_resultE,
    output logic            mul_doneE,
    output logic            stall_mulE,
    output logic            busyE
);

    mul_state_t        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [XLEN-1:0]   mcand_q;
    logic [XLEN-1:0]   mplier_q;
    logic [2*XLEN-1:0] acc_q;
    logic [2*XLEN-1:0] acc_d;
    logic              neg_q;
    logic [2:0]        f3_q;
    logic [XLEN-1:0]   result_q;
    logic              done_q;
    logic              busy_q;

    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic              neg;
    logic [XLEN-1:0]   fix_result;

    mul_sign_fix u_sign_fix (
        .funct3_i     (funct3E),
        .src_a_i      (SrcAE),
        .src_b_i      (SrcBE),
        .mag_a_o      (mag_a),
        .mag_b_o      (mag_b),
        .neg_o        (neg),
        .res_funct3_i (f3_q),
        .res_neg_i    (neg_q),
        .prod_i       (acc_d),
        .result_o     (fix_result)
    );

    always_comb begin
        acc_d = acc_q;
        if (mplier_q[0])
            acc_d = acc_q + ({{XLEN{1'b0}}, mcand_q} << cnt_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            f3_q     <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (startE && !flushE) begin
                        mcand_q  <= mag_a;
                        mplier_q <= mag_b;
                        neg_q    <= neg;
                        f3_q     <= funct3E;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= BUSY;
                    end
                end
                BUSY: begin
                    if (flushE) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        acc_q    <= acc_d;
                        mplier_q <= mplier_q >> 1;
                        cnt_q    <= cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(XLEN - 1)) begin
                            result_q <= fix_result;
                            done_q   <= 1'b1;
                            busy_q   <= 1'b0;
                            state_q  <= DONE;
                        end
                    end
                end
                DONE: begin
                    // the instruction that produced this result is still in EX; never restart on it
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign stall_mulE         = ((state_q == IDLE) && startE && !flushE) || (state_q == BUSY);
    assign busyE              = busy_q;
    assign mul_doneE          = done_q;
    assign multiplier_resultE = result_q;

endmodule

// File: tb/tb_mul_unit_ex.sv
// Self-checking bench for mul_unit_ex: directed cases plus randomized ops against a 64-bit arithmetic model.
module tb_mul_unit_ex;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        startE;
    logic        flushE;
    logic [2:0]  funct3E;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic [31:0] multiplier_resultE;
    logic        mul_doneE;
    logic        stall_mulE;
    logic        busyE;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mul_unit_ex dut (
        .clk                (clk),
        .reset              (reset),
        .startE             (startE),
        .flushE             (flushE),
        .funct3E            (funct3E),
        .SrcAE              (SrcAE),
        .SrcBE              (SrcBE),
        .multiplier_resultE (multiplier_resultE),
        .mul_doneE          (mul_doneE),
        .stall_mulE         (stall_mulE),
        .busyE              (busyE)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_mul(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ub_s;
        logic [63:0] ua, ub, p;
        sa   = $signed({{32{a[31]}}, a});
        sb   = $signed({{32{b[31]}}, b});
        ua   = {32'd0, a};
        ub   = {32'd0, b};
        ub_s = $signed(ub);
        case (f3)
            F3_MULH:   p = sa * sb;
            F3_MULHSU: p = sa * ub_s;
            F3_MULHU:  p = ua * ub;
            default:   p = ua * ub;
        endcase
        if (f3 == F3_MULH || f3 == F3_MULHSU || f3 == F3_MULHU)
            return p[63:32];
        return p[31:0];
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 9))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts an op at the current cycle T, leaves startE high and returns at the start of T+34.
    task automatic mul_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string tag);
        int  cyc;
        int  stalls;
        bit  seen;
        funct3E = f3;
        SrcAE   = a;
        SrcBE   = b;
        startE  = 1'b1;
        cyc     = 0;
        stalls  = 0;
        seen    = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            if (mul_doneE) begin
                seen = 1'b1;
            end else begin
                stalls += int'(stall_mulE);
                step();
                cyc++;
            end
        end
        check({tag, ".latency"}, 32'(cyc), 32'd33);
        check({tag, ".stalls"}, 32'(stalls), 32'd33);
        check({tag, ".stall_in_done"}, {31'd0, stall_mulE}, 32'd0);
        check({tag, ".result"}, multiplier_resultE, exp);
        step();
    endtask

    initial begin
        int dn;
        logic [2:0]  f3;
        logic [31:0] a, b;

        reset   = 1'b1;
        startE  = 1'b0;
        flushE  = 1'b0;
        funct3E = 3'd0;
        SrcAE   = '0;
        SrcBE   = '0;
        step();
        step();
        @(negedge clk);
        check("rst.result", multiplier_resultE, 32'd0);
        check("rst.done", {31'd0, mul_doneE}, 32'd0);
        check("rst.stall", {31'd0, stall_mulE}, 32'd0);
        check("rst.busy", {31'd0, busyE}, 32'd0);
        step();
        reset = 1'b0;

        mul_op(F3_MUL, 32'd7, 32'd6, 32'h0000_002A, "mul7x6");
        startE = 1'b0;
        @(negedge clk);
        check("mul7x6.done_one_cycle", {31'd0, mul_doneE}, 32'd0);
        check("mul7x6.idle_busy", {31'd0, busyE}, 32'd0);
        step();

        mul_op(F3_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_min");
        mul_op(F3_MUL,    32'hFFFF_FFFF, 32'h0000_0003, 32'hFFFF_FFFD, "mul_m1x3");
        mul_op(F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1");
        mul_op(F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max");
        startE = 1'b0;
        step();

        mul_op(F3_MUL,   32'd2,       32'd3,       32'h0000_0006, "b2b_first");
        mul_op(F3_MULHU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, "b2b_second");
        startE = 1'b0;
        step();

        // reset in the middle of an operation
        funct3E = F3_MUL;
        SrcAE   = 32'd9;
        SrcBE   = 32'd9;
        startE  = 1'b1;
        step();
        repeat (9) step();
        reset  = 1'b1;
        startE = 1'b0;
        step();
        reset = 1'b0;
        @(negedge clk);
        check("midrst.busy", {31'd0, busyE}, 32'd0);
        check("midrst.stall", {31'd0, stall_mulE}, 32'd0);
        check("midrst.done", {31'd0, mul_doneE}, 32'd0);
        check("midrst.result", multiplier_resultE, 32'd0);
        step();
        mul_op(F3_MUL, 32'd3, 32'd5, 32'h0000_000F, "after_rst");
        startE = 1'b0;
        step();

        // flush while busy: no done pulse, result keeps its value
        funct3E = F3_MULHU;
        SrcAE   = 32'hFFFF_FFFF;
        SrcBE   = 32'hFFFF_FFFF;
        startE  = 1'b1;
        step();
        repeat (4) step();
        flushE = 1'b1;
        startE = 1'b0;
        step();
        flushE = 1'b0;
        dn = 0;
        repeat (40) begin
            @(negedge clk);
            dn += int'(mul_doneE);
        end
        check("flush.no_done", 32'(dn), 32'd0);
        check("flush.busy", {31'd0, busyE}, 32'd0);
        check("flush.result", multiplier_resultE, 32'h0000_000F);
        step();

        // flush in IDLE blocks acceptance
        startE = 1'b1;
        flushE = 1'b1;
        @(negedge clk);
        check("idleflush.stall", {31'd0, stall_mulE}, 32'd0);
        step();
        startE = 1'b0;
        flushE = 1'b0;
        @(negedge clk);
        check("idleflush.busy", {31'd0, busyE}, 32'd0);
        step();

        for (int i = 0; i < 1500; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = pick_operand();
            b  = pick_operand();
            mul_op(f3, a, b, ref_mul(f3, a, b), "rnd");
            if ($urandom_range(0, 3) == 0) begin
                startE = 1'b0;
                step();
            end
        end
        startE = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
